gate_sequencer: RTL

- Sequences one evaluation of a `gate` instance together with its two weightRAMs: X holds HIDDEN_SZ x INPUT_SZ weights, Y holds HIDDEN_SZ x HIDDEN_SZ weights.
- Accepts a stream of weight columns and writes them into the RAMs, holding the gate in reset while it does so.
- Then pulses beginCalc, waits for dataReady, captures gateOutput and presents it on a valid/ready output port.
- Replaces the hand-sequenced load/fire loop used in simulation, so an LSTM-level controller can drive gates autonomously.

---
 rtl/gate_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/gate_sequencer.sv
// Sequencer for one gate evaluation: streams weight columns into the X/Y weightRAMs
// with the gate held in reset, fires beginCalc, then hands the result out over valid/ready.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting weight columns, gate held in reset
// FLUSH | last RAM write strobe on the bus, gate still in reset
// FIRE  | single-cycle beginCalc pulse
// WAIT  | watching for a dataReady rising edge, watchdog running
// OUT   | result presented until out_ready
module gate_sequencer #(
    parameter int INPUT_SZ        = 2,
    parameter int HIDDEN_SZ       = 16,
    parameter int QN              = 6,
    parameter int QM              = 11,
    parameter int TIMEOUT         = 1024,
    parameter int BITWIDTH        = QN + QM + 1,
    parameter int LAYER_BITWIDTH  = BITWIDTH * HIDDEN_SZ,
    parameter int ADDR_BITWIDTH   = $clog2(HIDDEN_SZ),
    parameter int ADDR_BITWIDTH_X = (INPUT_SZ > 1) ? $clog2(INPUT_SZ) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic [LAYER_BITWIDTH-1:0]  i_bias_in,
    input  logic                       i_col_valid,
    output logic                       o_col_ready,
    input  logic [LAYER_BITWIDTH-1:0]  i_col_wx,
    input  logic [LAYER_BITWIDTH-1:0]  i_col_wy,
    output logic [ADDR_BITWIDTH_X-1:0] o_colAddressWrite_X,
    output logic [ADDR_BITWIDTH-1:0]   o_colAddressWrite_Y,
    output logic                       o_writeEn_X,
    output logic                       o_writeEn_Y,
    output logic [LAYER_BITWIDTH-1:0]  o_weightMemInput_X,
    output logic [LAYER_BITWIDTH-1:0]  o_weightMemInput_Y,
    output logic [LAYER_BITWIDTH-1:0]  o_biasVec,
    output logic                       o_gate_reset,
    output logic                       o_beginCalc,
    input  logic                       i_dataReady_gate,
    input  logic [LAYER_BITWIDTH-1:0]  i_gateOutput,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [LAYER_BITWIDTH-1:0]  o_out_data,
    output logic                       o_busy,
    output logic                       o_error,
    output logic [15:0]                o_sample_count
);

    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0]        WDOG_LOAD = WDOG_W'(TIMEOUT - 1);
    localparam logic [ADDR_BITWIDTH-1:0] K_LAST    = ADDR_BITWIDTH'(HIDDEN_SZ - 1);
    localparam logic [ADDR_BITWIDTH:0]   X_COLS    = (ADDR_BITWIDTH + 1)'(INPUT_SZ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_FIRE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t                       r_state;
    logic [ADDR_BITWIDTH-1:0]     r_k;
    logic [WDOG_W-1:0]            r_wdog;
    logic                         r_dr_prev;
    logic                         r_col_ready;
    logic [ADDR_BITWIDTH_X-1:0]   r_addr_x;
    logic [ADDR_BITWIDTH-1:0]     r_addr_y;
    logic                         r_we_x;
    logic                         r_we_y;
    logic [LAYER_BITWIDTH-1:0]    r_din_x;
    logic [LAYER_BITWIDTH-1:0]    r_din_y;
    logic [LAYER_BITWIDTH-1:0]    r_bias;
    logic                         r_gate_reset;
    logic                         r_begin;
    logic                         r_out_valid;
    logic [LAYER_BITWIDTH-1:0]    r_out_data;
    logic                         r_busy;
    logic                         r_error;
    logic [15:0]                  r_sample_count;

    logic w_dr_rise;
    logic w_x_beat;

    // Only a fresh 0->1 transition counts, so a level left high by the previous run is ignored.
    assign w_dr_rise = i_dataReady_gate & ~r_dr_prev;
    assign w_x_beat  = ({1'b0, r_k} < X_COLS);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_k            <= '0;
            r_wdog         <= '0;
            r_dr_prev      <= 1'b0;
            r_col_ready    <= 1'b0;
            r_addr_x       <= '0;
            r_addr_y       <= '0;
            r_we_x         <= 1'b0;
            r_we_y         <= 1'b0;
            r_din_x        <= '0;
            r_din_y        <= '0;
            r_bias         <= '0;
            r_gate_reset   <= 1'b0;
            r_begin        <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
            r_sample_count <= '0;
        end else begin
            r_dr_prev <= i_dataReady_gate;
            r_we_x    <= 1'b0;
            r_we_y    <= 1'b0;
            r_begin   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_bias       <= i_bias_in;
                        r_k          <= '0;
                        r_col_ready  <= 1'b1;
                        r_gate_reset <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (i_col_valid) begin
                        r_we_y   <= 1'b1;
                        r_addr_y <= r_k;
                        r_din_y  <= i_col_wy;
                        if (w_x_beat) begin
                            r_we_x   <= 1'b1;
                            r_addr_x <= r_k[ADDR_BITWIDTH_X-1:0];
                            r_din_x  <= i_col_wx;
                        end
                        if (r_k == K_LAST) begin
                            r_col_ready <= 1'b0;
                            r_state     <= S_FLUSH;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end

                S_FLUSH: begin
                    r_gate_reset <= 1'b0;
                    r_begin      <= 1'b1;
                    r_state      <= S_FIRE;
                end

                S_FIRE: begin
                    r_wdog  <= WDOG_LOAD;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    // A completion arriving on the last watchdog cycle still wins.
                    if (w_dr_rise) begin
                        r_out_data     <= i_gateOutput;
                        r_out_valid    <= 1'b1;
                        r_sample_count <= r_sample_count + 16'd1;
                        r_state        <= S_OUT;
                    end else if (r_wdog == '0) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog - 1'b1;
                    end
                end

                S_OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (i_start) begin
                            r_bias       <= i_bias_in;
                            r_k          <= '0;
                            r_col_ready  <= 1'b1;
                            r_gate_reset <= 1'b1;
                            r_state      <= S_LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_col_ready  <= 1'b0;
                    r_gate_reset <= 1'b0;
                    r_out_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign o_col_ready         = r_col_ready;
    assign o_colAddressWrite_X = r_addr_x;
    assign o_colAddressWrite_Y = r_addr_y;
    assign o_writeEn_X         = r_we_x;
    assign o_writeEn_Y         = r_we_y;
    assign o_weightMemInput_X  = r_din_x;
    assign o_weightMemInput_Y  = r_din_y;
    assign o_biasVec           = r_bias;
    assign o_gate_reset        = r_gate_reset;
    assign o_beginCalc         = r_begin;
    assign o_out_valid         = r_out_valid;
    assign o_out_data          = r_out_data;
    assign o_busy              = r_busy;
    assign o_error             = r_error;
    assign o_sample_count      = r_sample_count;

endmodule
